// File: rtl/jzjpcc_wbarbiter.sv
// Register-file write-port arbiter between pipeline writeback and the multicycle unit,
// with a pending-destination scoreboard and starvation hold. Optional counters: JZJPCC_WBARB_COUNTERS_EN.
module jzjpcc_wbarbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  wbAddr,
  input  logic [31:0] wbData,
  input  logic        wbWriteEn,
  input  logic        issueValid,
  input  logic [4:0]  issueRd,
  output logic        issueReady,
  input  logic        mcuValid,
  input  logic [4:0]  mcuRd,
  input  logic [31:0] mcuData,
  output logic        mcuReady,
  input  logic [4:0]  rs1Addr,
  input  logic [4:0]  rs2Addr,
  input  logic [4:0]  decodeRd,
  output logic        hazardStall,
  output logic        pipelineHold,
  output logic [4:0]  rdAddr,
  output logic [31:0] rd,
  output logic        rdWriteEn
`ifdef JZJPCC_WBARB_COUNTERS_EN
  ,
  output logic [31:0] conflictCount,
  output logic [31:0] starveCount
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Bit 0 is kept at zero so x0 can be indexed like any other register.
  logic [31:0] pending_q, pending_d;
  logic [3:0]  wait_count_q, wait_count_d;
  logic        hold_q, hold_d;

  logic        mcu_win;
  logic        pipe_win;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mcu_win   = 1'b0;
    pipe_win  = 1'b0;
    rdAddr    = 5'd0;
    rd        = 32'd0;
    rdWriteEn = 1'b0;

    if (hold_q) begin
      mcu_win = mcuValid;
    end else if (wbWriteEn) begin
      pipe_win = 1'b1;
    end else begin
      mcu_win = mcuValid;
    end

    if (pipe_win) begin
      rdAddr    = wbAddr;
      rd        = wbData;
      rdWriteEn = (wbAddr != 5'd0);
    end else if (mcu_win) begin
      rdAddr    = mcuRd;
      rd        = mcuData;
      rdWriteEn = (mcuRd != 5'd0);
    end
  end

  assign mcuReady     = mcu_win;
  assign pipelineHold = hold_q;

  // Acceptance looks only at the registered scoreboard, never at a same-cycle clear.
  assign issueReady  = issueValid && ((issueRd == 5'd0) || !pending_q[issueRd]);
  assign hazardStall = ((rs1Addr  != 5'd0) && pending_q[rs1Addr])  ||
                       ((rs2Addr  != 5'd0) && pending_q[rs2Addr])  ||
                       ((decodeRd != 5'd0) && pending_q[decodeRd]);

  always_comb begin
    pending_d = pending_q;
    if (issueReady && (issueRd != 5'd0)) pending_d[issueRd] = 1'b1;
    if (mcu_win && (mcuRd != 5'd0))      pending_d[mcuRd]   = 1'b0;
    pending_d[0] = 1'b0;

    wait_count_d = 4'd0;
    if (mcuValid && !mcu_win) begin
      wait_count_d = (wait_count_q >= LIMIT) ? LIMIT : wait_count_q + 4'd1;
    end
    hold_d = (wait_count_d == LIMIT) && !mcu_win;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q    <= 32'd0;
      wait_count_q <= 4'd0;
      hold_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      pending_q    <= pending_d;
      wait_count_q <= wait_count_d;
      hold_q       <= hold_d;
    end
  end

`ifdef JZJPCC_WBARB_COUNTERS_EN
  logic [31:0] conflict_count_q, conflict_count_d;
  logic [31:0] starve_count_q, starve_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q + {31'd0, (wbWriteEn && mcuValid)};
    starve_count_d   = starve_count_q + {31'd0, hold_d};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_count_q <= 32'd0;
      starve_count_q   <= 32'd0;
    end else begin
      conflict_count_q <= conflict_count_d;
      starve_count_q   <= starve_count_d;
    end
  end

  assign conflictCount = conflict_count_q;
  assign starveCount   = starve_count_q;
`endif

  // Protocol checks on the upstream stages.
  a_no_wb_during_hold: assert property (@(posedge clock) disable iff (reset)
    !(hold_q && wbWriteEn));
  a_no_wb_to_pending: assert property (@(posedge clock) disable iff (reset)
    !(wbWriteEn && (wbAddr != 5'd0) && pending_q[wbAddr]));

endmodule

// File: tb/tb_jzjpcc_wbarbiter.sv
// Self-checking bench for jzjpcc_wbarbiter: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the arbitration rules.
module tb_jzjpcc_wbarbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        wbWriteEn;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic        issueReady;
  logic        mcuValid;
  logic [4:0]  mcuRd;
  logic [31:0] mcuData;
  logic        mcuReady;
  logic [4:0]  rs1Addr, rs2Addr, decodeRd;
  logic        hazardStall, pipelineHold;
  logic [4:0]  rdAddr;
  logic [31:0] rd;
  logic        rdWriteEn;
`ifdef JZJPCC_WBARB_COUNTERS_EN
  logic [31:0] conflictCount, starveCount;
`endif

  jzjpcc_wbarbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wbAddr(wbAddr), .wbData(wbData), .wbWriteEn(wbWriteEn),
    .issueValid(issueValid), .issueRd(issueRd), .issueReady(issueReady),
    .mcuValid(mcuValid), .mcuRd(mcuRd), .mcuData(mcuData), .mcuReady(mcuReady),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .decodeRd(decodeRd),
    .hazardStall(hazardStall), .pipelineHold(pipelineHold),
    .rdAddr(rdAddr), .rd(rd), .rdWriteEn(rdWriteEn)
`ifdef JZJPCC_WBARB_COUNTERS_EN
    , .conflictCount(conflictCount), .starveCount(starveCount)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: set of outstanding destinations, run length of refused MCU cycles.
  bit [31:0] m_pend, n_pend;
  int        m_waited, n_waited;
  bit        m_hold, n_hold;
  int        m_conf, n_conf, m_starve, n_starve;

  always @(negedge clock) begin
    bit mcu_w, pipe_w, e_ir, e_hz, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    if (reset) begin
      n_pend = 0; n_waited = 0; n_hold = 0; n_conf = 0; n_starve = 0;
    end else begin
      pipe_w = !m_hold && wbWriteEn;
      mcu_w  = mcuValid && !pipe_w;
      e_addr = pipe_w ? wbAddr : (mcu_w ? mcuRd : 5'd0);
      e_data = pipe_w ? wbData : (mcu_w ? mcuData : 32'd0);
      e_we   = (pipe_w || mcu_w) && (e_addr != 5'd0);
      e_ir   = issueValid && (issueRd == 5'd0 || !m_pend[issueRd]);
      e_hz   = (rs1Addr != 0 && m_pend[rs1Addr]) || (rs2Addr != 0 && m_pend[rs2Addr]) ||
               (decodeRd != 0 && m_pend[decodeRd]);
      check("m_mcuReady",     mcuReady,     mcu_w);
      check("m_rdAddr",       rdAddr,       e_addr);
      check("m_rd",           rd,           e_data);
      check("m_rdWriteEn",    rdWriteEn,    e_we);
      check("m_issueReady",   issueReady,   e_ir);
      check("m_hazardStall",  hazardStall,  e_hz);
      check("m_pipelineHold", pipelineHold, m_hold);
`ifdef JZJPCC_WBARB_COUNTERS_EN
      check("m_conflictCount", conflictCount, m_conf);
      check("m_starveCount",   starveCount,   m_starve);
`endif
      n_pend = m_pend;
      if (e_ir && issueRd != 0) n_pend[issueRd] = 1'b1;
      if (mcu_w && mcuRd != 0)  n_pend[mcuRd]   = 1'b0;
      n_waited = (mcuValid && !mcu_w) ? m_waited + 1 : 0;
      n_hold   = (mcuValid && !mcu_w) && (n_waited >= LIMIT);
      n_conf   = m_conf + ((wbWriteEn && mcuValid) ? 1 : 0);
      n_starve = m_starve + (n_hold ? 1 : 0);
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend <= 0; m_waited <= 0; m_hold <= 0; m_conf <= 0; m_starve <= 0;
    end else begin
      m_pend <= n_pend; m_waited <= n_waited; m_hold <= n_hold;
      m_conf <= n_conf; m_starve <= n_starve;
    end
  end

  task automatic idle();
    wbAddr = 0; wbData = 0; wbWriteEn = 0;
    issueValid = 0; issueRd = 0;
    mcuValid = 0; mcuRd = 0; mcuData = 0;
    rs1Addr = 0; rs2Addr = 0; decodeRd = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    #2;
    check("reset_hold", pipelineHold, 0);
    check("reset_we",   rdWriteEn,    0);
    check("reset_hz",   hazardStall,  0);
    next_cycle(); next_cycle();
    reset = 1'b0;

    // Reset in the middle of an outstanding MCU op
    issueValid = 1; issueRd = 5;
    #2 check("x5_issue_ready", issueReady, 1);
    next_cycle();
    idle(); rs1Addr = 5;
    #2 check("x5_hazard", hazardStall, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_hazard", hazardStall,  0);
    check("rst_mid_hold",   pipelineHold, 0);
    check("rst_mid_we",     rdWriteEn,    0);
    next_cycle();
    reset = 1'b0;
    #2 check("rst_post_hazard", hazardStall, 0);
    next_cycle();

    // Issue x7, hazard on rs2, MCU returns result
    idle(); issueValid = 1; issueRd = 7;
    #2 check("x7_issue_ready", issueReady, 1);
    next_cycle();
    idle(); rs2Addr = 7;
    #2 check("x7_hazard", hazardStall, 1);
    next_cycle();
    mcuValid = 1; mcuRd = 7; mcuData = 32'hDEADBEEF;
    #2;
    check("x7_rdAddr",    rdAddr,    7);
    check("x7_rd",        rd,        32'hDEADBEEF);
    check("x7_we",        rdWriteEn, 1);
    check("x7_mcuReady",  mcuReady,  1);
    check("x7_hz_before", hazardStall, 1);
    next_cycle();
    mcuValid = 0;
    #2 check("x7_hz_after", hazardStall, 0);
    next_cycle();

    // Conflict: pipeline wins LIMIT cycles, then the hold grants the MCU
    for (int rep = 0; rep < 2; rep++) begin
      idle();
      wbWriteEn = 1; wbAddr = 3; wbData = 32'h11;
      mcuValid  = 1; mcuRd  = 4; mcuData = 32'h22;
      for (int i = 0; i < LIMIT; i++) begin
        #2;
        check("conf_pipe_addr", rdAddr, 3);
        check("conf_pipe_data", rd, 32'h11);
        check("conf_mcu_ready", mcuReady, 0);
        check("conf_no_hold",   pipelineHold, 0);
        next_cycle();
      end
      wbWriteEn = 0;
      #2;
      check("hold_up",       pipelineHold, 1);
      check("hold_mcu_addr", rdAddr, 4);
      check("hold_mcu_data", rd, 32'h22);
      check("hold_mcu_rdy",  mcuReady, 1);
      next_cycle();
      mcuValid = 0;
      #2 check("hold_down", pipelineHold, 0);
      next_cycle();
    end

    // Double issue to x9 and issue in the cycle x9 retires
    idle(); issueValid = 1; issueRd = 9;
    #2 check("x9_first", issueReady, 1);
    next_cycle();
    #2 check("x9_second", issueReady, 0);
    next_cycle();
    issueValid = 0; decodeRd = 9;
    #2 check("x9_still_pend", hazardStall, 1);
    next_cycle();
    decodeRd = 0; issueValid = 1; issueRd = 9;
    mcuValid = 1; mcuRd = 9; mcuData = 32'h99;
    #2;
    check("x9_same_cycle", issueReady, 0);
    check("x9_retire_rdy", mcuReady, 1);
    next_cycle();
    mcuValid = 0;
    #2 check("x9_after", issueReady, 1);
    next_cycle();
    // Set x10 while clearing x9 in the same cycle
    issueRd = 10; mcuValid = 1; mcuRd = 9; mcuData = 32'h5A;
    #2 check("x10_issue", issueReady, 1);
    next_cycle();
    idle(); rs1Addr = 9;
    #2 check("x9_cleared", hazardStall, 0);
    rs1Addr = 0; decodeRd = 10;
    #1 check("x10_set", hazardStall, 1);
    next_cycle();
    idle(); mcuValid = 1; mcuRd = 10;
    next_cycle();

    // x0 from both sources and issue to x0
    idle(); wbWriteEn = 1; wbAddr = 0; wbData = 32'h55;
    #2;
    check("x0_wb_we",   rdWriteEn, 0);
    check("x0_wb_addr", rdAddr, 0);
    next_cycle();
    idle(); mcuValid = 1; mcuRd = 0; mcuData = 32'h66;
    #2;
    check("x0_mcu_we",  rdWriteEn, 0);
    check("x0_mcu_rdy", mcuReady, 1);
    next_cycle();
    idle(); issueValid = 1; issueRd = 0;
    #2 check("x0_issue", issueReady, 1);
    next_cycle();
    idle(); issueValid = 1; issueRd = 0;
    #2 check("x0_issue_again", issueReady, 1);
    check("x0_no_hazard", hazardStall, 0);
    next_cycle();

    // Constrained-random traffic checked by the model; legal protocol only
    for (int c = 0; c < 300; c++) begin
      idle();
      wbAddr = 5'($urandom_range(0, 15));
      wbData = $urandom;
      wbWriteEn = !m_hold && ($urandom_range(0, 2) != 0) && !m_pend[wbAddr];
      issueValid = $urandom_range(0, 1) == 1;
      issueRd = 5'($urandom_range(0, 15));
      mcuValid = $urandom_range(0, 2) != 0;
      mcuRd = 5'($urandom_range(0, 15));
      mcuData = $urandom;
      rs1Addr = 5'($urandom_range(0, 15));
      rs2Addr = 5'($urandom_range(0, 15));
      decodeRd = 5'($urandom_range(0, 15));
      next_cycle();
    end

    idle();
    next_cycle(); next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
